avalon_word_mover: RTL and testbench

AVALON_WORD_MOVER -- requirements
Module: avalon_word_mover

---
 rtl/mover_pkg.sv | 35 +++
 rtl/mover_csr.sv | 129 ++++++++++++
 rtl/avalon_word_mover.sv | 198 +++++++++++++++++++
 tb/tb_avalon_word_mover.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mover_pkg.sv
// Shared constants and types for the Avalon word mover: CSR indices,
// CTRL/STATUS bit positions and the transfer FSM state type.
package mover_pkg;

  localparam int CSR_CTRL     = 0;
  localparam int CSR_STATUS   = 1;
  localparam int CSR_SRC      = 2;
  localparam int CSR_DST      = 3;
  localparam int CSR_LEN      = 4;
  localparam int CSR_COUNT    = 5;
  localparam int CSR_CHECKSUM = 6;
  localparam int CSR_SCRATCH  = 7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // States that own a master command (and therefore defer an abort).
  function automatic logic state_is_active(input state_e s);
    return (s == ST_RD_REQ) || (s == ST_RD_WAIT) || (s == ST_WR_REQ);
  endfunction

endpackage

// File: rtl/mover_csr.sv
// Slave register file of the word mover: CTRL pulses, STATUS flags,
// SRC/DST/LEN configuration, SCRATCH and the 1-cycle read-data register.
module mover_csr
  import mover_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32,
  parameter int LENWIDTH            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  input  logic                           busy,
  input  logic                           clear_status,
  input  logic                           set_done,
  input  logic                           set_aborted,
  input  logic [LENWIDTH-1:0]            count,
  input  logic [DATAWIDTH-1:0]           checksum,
  output logic                           start_pulse,
  output logic                           abort_pulse,
  output logic [MASTER_ADDRESSWIDTH-1:0] src,
  output logic [MASTER_ADDRESSWIDTH-1:0] dst,
  output logic [LENWIDTH-1:0]            len,
  output logic                           irq
);

  logic                           wr_s;
  logic                           rd_s;
  logic                           wr_ctrl_s;
  logic                           wr_status_s;
  logic                           wr_src_s;
  logic                           wr_dst_s;
  logic                           wr_len_s;
  logic                           wr_scratch_s;
  logic [DATAWIDTH-1:0]           rd_mux_s;

  logic                           irq_en_r;
  logic                           done_r;
  logic                           aborted_r;
  logic                           start_r;
  logic                           abort_r;
  logic [MASTER_ADDRESSWIDTH-1:0] src_r;
  logic [MASTER_ADDRESSWIDTH-1:0] dst_r;
  logic [LENWIDTH-1:0]            len_r;
  logic [DATAWIDTH-1:0]           scratch_r;
  logic [DATAWIDTH-1:0]           readdata_r;

  assign wr_s         = slave_write && slave_chipselect;
  assign rd_s         = slave_read && slave_chipselect;
  assign wr_ctrl_s    = wr_s && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_CTRL));
  assign wr_status_s  = wr_s && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_STATUS));
  assign wr_src_s     = wr_s && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_SRC));
  assign wr_dst_s     = wr_s && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_DST));
  assign wr_len_s     = wr_s && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_LEN));
  assign wr_scratch_s = wr_s && (slave_address == SLAVE_ADDRESSWIDTH'(CSR_SCRATCH));

  // Register writes; start is suppressed when abort arrives in the same write.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_r  <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      start_r   <= 1'b0;
      abort_r   <= 1'b0;
      src_r     <= '0;
      dst_r     <= '0;
      len_r     <= '0;
      scratch_r <= '0;
    end else begin
      start_r <= wr_ctrl_s && slave_writedata[CTRL_START] && !slave_writedata[CTRL_ABORT];
      abort_r <= wr_ctrl_s && slave_writedata[CTRL_ABORT];
      if (wr_ctrl_s) irq_en_r <= slave_writedata[CTRL_IRQ_EN];
      if (wr_src_s && !busy) src_r <= slave_writedata[MASTER_ADDRESSWIDTH-1:0];
      if (wr_dst_s && !busy) dst_r <= slave_writedata[MASTER_ADDRESSWIDTH-1:0];
      if (wr_len_s && !busy) len_r <= slave_writedata[LENWIDTH-1:0];
      if (wr_scratch_s) scratch_r <= slave_writedata;
      if (clear_status) begin
        done_r    <= 1'b0;
        aborted_r <= 1'b0;
      end else begin
        if (set_done) done_r <= 1'b1;
        else if (wr_status_s && slave_writedata[STAT_DONE]) done_r <= 1'b0;
        if (set_aborted) aborted_r <= 1'b1;
        else if (wr_status_s && slave_writedata[STAT_ABORTED]) aborted_r <= 1'b0;
      end
    end
  end

  // Read multiplexer, zero-filling every unused bit.
  always_comb begin
    rd_mux_s = '0;
    case (slave_address)
      SLAVE_ADDRESSWIDTH'(CSR_CTRL):     rd_mux_s[CTRL_IRQ_EN] = irq_en_r;
      SLAVE_ADDRESSWIDTH'(CSR_STATUS): begin
        rd_mux_s[STAT_BUSY]    = busy;
        rd_mux_s[STAT_DONE]    = done_r;
        rd_mux_s[STAT_ABORTED] = aborted_r;
      end
      SLAVE_ADDRESSWIDTH'(CSR_SRC):      rd_mux_s[MASTER_ADDRESSWIDTH-1:0] = src_r;
      SLAVE_ADDRESSWIDTH'(CSR_DST):      rd_mux_s[MASTER_ADDRESSWIDTH-1:0] = dst_r;
      SLAVE_ADDRESSWIDTH'(CSR_LEN):      rd_mux_s[LENWIDTH-1:0] = len_r;
      SLAVE_ADDRESSWIDTH'(CSR_COUNT):    rd_mux_s[LENWIDTH-1:0] = count;
      SLAVE_ADDRESSWIDTH'(CSR_CHECKSUM): rd_mux_s = checksum;
      SLAVE_ADDRESSWIDTH'(CSR_SCRATCH):  rd_mux_s = scratch_r;
      default:                           rd_mux_s = '0;
    endcase
  end

  // Read data register: one clock of latency, holds between reads.
  always_ff @(posedge clk) begin
    if (reset) readdata_r <= '0;
    else if (rd_s) readdata_r <= rd_mux_s;
  end

  assign slave_readdata = readdata_r;
  assign start_pulse    = start_r;
  assign abort_pulse    = abort_r;
  assign src            = src_r;
  assign dst            = dst_r;
  assign len            = len_r;
  assign irq            = done_r && irq_en_r;

endmodule

// File: rtl/avalon_word_mover.sv
// Avalon-MM word mover: copies LEN words from SRC to DST one read/write at a time.
// Optional MOVER_CHECKSUM_EN builds a running sum of every word written.
module avalon_word_mover
  import mover_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32,
  parameter int LENWIDTH            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           irq
);

  localparam logic [MASTER_ADDRESSWIDTH-1:0] ADDR_STEP = MASTER_ADDRESSWIDTH'(3'd4);

  state_e                         state_r;
  state_e                         state_nx;
  logic                           start_s;
  logic                           abort_s;
  logic                           busy_s;
  logic                           start_go_s;
  logic                           abort_pend_s;
  logic                           rd_accept_s;
  logic                           rd_valid_s;
  logic                           wr_accept_s;
  logic                           last_word_s;
  logic                           abort_exit_s;
  logic                           set_done_s;
  logic [MASTER_ADDRESSWIDTH-1:0] src_cfg_s;
  logic [MASTER_ADDRESSWIDTH-1:0] dst_cfg_s;
  logic [LENWIDTH-1:0]            len_cfg_s;
  logic [LENWIDTH-1:0]            count_inc_s;
  logic [DATAWIDTH-1:0]           checksum_s;

  logic [MASTER_ADDRESSWIDTH-1:0] src_r;
  logic [MASTER_ADDRESSWIDTH-1:0] dst_r;
  logic [LENWIDTH-1:0]            len_r;
  logic [LENWIDTH-1:0]            count_r;
  logic [DATAWIDTH-1:0]           data_r;
  logic                           abort_pending_r;

  mover_csr #(
    .MASTER_ADDRESSWIDTH (MASTER_ADDRESSWIDTH),
    .SLAVE_ADDRESSWIDTH  (SLAVE_ADDRESSWIDTH),
    .DATAWIDTH           (DATAWIDTH),
    .LENWIDTH            (LENWIDTH)
  ) u_csr (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_writedata  (slave_writedata),
    .slave_write      (slave_write),
    .slave_read       (slave_read),
    .slave_chipselect (slave_chipselect),
    .slave_readdata   (slave_readdata),
    .busy             (busy_s),
    .clear_status     (start_go_s),
    .set_done         (set_done_s),
    .set_aborted      (abort_exit_s),
    .count            (count_r),
    .checksum         (checksum_s),
    .start_pulse      (start_s),
    .abort_pulse      (abort_s),
    .src              (src_cfg_s),
    .dst              (dst_cfg_s),
    .len              (len_cfg_s),
    .irq              (irq)
  );

  assign busy_s       = (state_r != ST_IDLE);
  assign start_go_s   = (state_r == ST_IDLE) && start_s;
  assign abort_pend_s = abort_pending_r || abort_s;
  assign rd_accept_s  = (state_r == ST_RD_REQ) && !master_waitrequest;
  assign rd_valid_s   = (state_r == ST_RD_WAIT) && master_readdatavalid;
  assign wr_accept_s  = (state_r == ST_WR_REQ) && !master_waitrequest;
  assign count_inc_s  = count_r + LENWIDTH'(1'b1);
  assign last_word_s  = (count_inc_s == len_r);
  assign abort_exit_s = state_is_active(state_r) && (state_nx == ST_IDLE);
  assign set_done_s   = (state_r == ST_DONE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else state_r <= state_nx;
  end

  // Next state; an abort only exits once the outstanding command has completed.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx = (len_cfg_s == '0) ? ST_DONE : ST_RD_REQ;
        else state_nx = ST_IDLE;
      end
      ST_RD_REQ: begin
        if (rd_accept_s) state_nx = abort_pend_s ? ST_IDLE : ST_RD_WAIT;
        else state_nx = ST_RD_REQ;
      end
      ST_RD_WAIT: begin
        if (rd_valid_s) state_nx = abort_pend_s ? ST_IDLE : ST_WR_REQ;
        else state_nx = ST_RD_WAIT;
      end
      ST_WR_REQ: begin
        if (wr_accept_s) begin
          if (abort_pend_s) state_nx = ST_IDLE;
          else if (last_word_s) state_nx = ST_DONE;
          else state_nx = ST_RD_REQ;
        end else begin
          state_nx = ST_WR_REQ;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Master command outputs, all-zero outside the request states.
  always_comb begin
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (state_r)
      ST_RD_REQ: begin
        master_read    = 1'b1;
        master_address = src_r;
      end
      ST_WR_REQ: begin
        master_write     = 1'b1;
        master_address   = dst_r;
        master_writedata = data_r;
      end
      default: begin
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
      end
    endcase
  end

  // Working pointers, word counter, data capture and pending-abort flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r           <= '0;
      dst_r           <= '0;
      len_r           <= '0;
      count_r         <= '0;
      data_r          <= '0;
      abort_pending_r <= 1'b0;
    end else begin
      if (start_go_s) begin
        src_r   <= src_cfg_s;
        dst_r   <= dst_cfg_s;
        len_r   <= len_cfg_s;
        count_r <= '0;
      end else if (wr_accept_s) begin
        count_r <= count_inc_s;
        src_r   <= src_r + ADDR_STEP;
        dst_r   <= dst_r + ADDR_STEP;
      end
      if (rd_valid_s && !abort_pend_s) data_r <= master_readdata;
      if (!state_is_active(state_r) || abort_exit_s) abort_pending_r <= 1'b0;
      else if (abort_s) abort_pending_r <= 1'b1;
    end
  end

`ifdef MOVER_CHECKSUM_EN
  logic [DATAWIDTH-1:0] checksum_r;

  // Running modulo-2^DATAWIDTH sum of accepted write words.
  always_ff @(posedge clk) begin
    if (reset) checksum_r <= '0;
    else if (start_go_s) checksum_r <= '0;
    else if (wr_accept_s) checksum_r <= checksum_r + data_r;
  end

  assign checksum_s = checksum_r;
`else
  assign checksum_s = '0;
`endif

endmodule

// File: tb/tb_avalon_word_mover.sv
// Scoreboard bench for avalon_word_mover: expected master commands and CSR
// read values are queued at stimulus time and checked by a monitor process.
module tb_avalon_word_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata;
  logic        slave_write;
  logic        slave_read;
  logic        slave_chipselect;
  logic [31:0] slave_readdata;
  logic [25:0] master_address;
  logic [31:0] master_writedata;
  logic        master_write;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;
  logic        irq;

  always #5 clk = ~clk;

  avalon_word_mover #(
    .MASTER_ADDRESSWIDTH (26),
    .SLAVE_ADDRESSWIDTH  (3),
    .DATAWIDTH           (32),
    .LENWIDTH            (16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .slave_address        (slave_address),
    .slave_writedata      (slave_writedata),
    .slave_write          (slave_write),
    .slave_read           (slave_read),
    .slave_chipselect     (slave_chipselect),
    .slave_readdata       (slave_readdata),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .irq                  (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rd_accepts = 0;
  int wr_accepts = 0;

  logic [31:0] mem [0:63];
  logic [25:0] exp_rd_q [$];
  logic [57:0] exp_wr_q [$];
  logic [31:0] exp_csr_q [$];
  string       exp_csr_name_q [$];

  // Memory model: waitrequest held wait_n cycles per command, readdatavalid 2 cycles after accept
  int          wait_n = 0;
  int          wcnt;
  logic [1:0]  rv_pipe;
  logic [31:0] rd_pipe0, rd_pipe1;
  logic        rd_armed;

  assign master_waitrequest   = (wcnt < wait_n);
  assign master_readdatavalid = rv_pipe[1];
  assign master_readdata      = rd_pipe1;

  always @(posedge clk) begin
    if (reset) begin
      wcnt <= 0; rv_pipe <= 2'b00; rd_pipe0 <= 32'h0; rd_pipe1 <= 32'h0;
    end else begin
      if (master_read || master_write) wcnt <= master_waitrequest ? wcnt + 1 : 0;
      else wcnt <= 0;
      rv_pipe  <= {rv_pipe[0], master_read && !master_waitrequest};
      rd_pipe0 <= mem[master_address[7:2]];
      rd_pipe1 <= rd_pipe0;
    end
  end

  always @(posedge clk) rd_armed <= slave_read && slave_chipselect && !reset;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: CSR read data, master command acceptance and held-command stability
  initial begin
    logic        hold_valid;
    logic [59:0] hold_cmd;
    logic [59:0] cur_cmd;
    hold_valid = 1'b0;
    hold_cmd   = '0;
    forever begin
      @(negedge clk);
      cur_cmd = {master_read, master_write, master_address, master_writedata};
      if (reset) begin
        hold_valid = 1'b0;
      end else begin
        if (rd_armed) begin
          if (exp_csr_q.size() == 0) chk("csr_rd_unexpected", slave_readdata, 64'hDEAD);
          else chk(exp_csr_name_q.pop_front(), slave_readdata, exp_csr_q.pop_front());
        end
        if (hold_valid) chk("cmd_stable", cur_cmd, hold_cmd);
        if (master_read && !master_waitrequest) begin
          rd_accepts++;
          if (exp_rd_q.size() == 0) chk("rd_unexpected", master_address, 64'hFFFF_FFFF);
          else chk("rd_addr", master_address, exp_rd_q.pop_front());
        end
        if (master_write && !master_waitrequest) begin
          wr_accepts++;
          if (exp_wr_q.size() == 0) chk("wr_unexpected", {master_address, master_writedata}, 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("wr_cmd", {master_address, master_writedata}, exp_wr_q.pop_front());
        end
        hold_valid = (master_read || master_write) && master_waitrequest;
        hold_cmd   = cur_cmd;
      end
    end
  end

  task automatic csr_write(input int a, input logic [31:0] d);
    @(negedge clk);
    slave_address = 3'(a); slave_writedata = d; slave_write = 1'b1; slave_chipselect = 1'b1;
    @(posedge clk);
    #1;
    slave_write = 1'b0; slave_chipselect = 1'b0;
  endtask

  task automatic csr_read(input int a, input logic [31:0] exp, input string name);
    @(negedge clk);
    exp_csr_q.push_back(exp);
    exp_csr_name_q.push_back(name);
    slave_address = 3'(a); slave_read = 1'b1; slave_chipselect = 1'b1;
    @(posedge clk);
    #1;
    slave_read = 1'b0; slave_chipselect = 1'b0;
  endtask

  task automatic push_read(input logic [25:0] s);
    exp_rd_q.push_back(s);
  endtask

  task automatic push_word(input logic [25:0] s, input logic [25:0] d);
    exp_rd_q.push_back(s);
    exp_wr_q.push_back({d, mem[s[7:2]]});
  endtask

  task automatic push_transfer(input logic [25:0] s, input logic [25:0] d, input int n);
    for (int i = 0; i < n; i++) push_word(s + 26'(4 * i), d + 26'(4 * i));
  endtask

  task automatic wait_irq(input string name);
    int k;
    k = 0;
    while (irq !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(name, irq, 1);
  endtask

  task automatic setup(input logic [25:0] s, input logic [25:0] d, input logic [15:0] n);
    csr_write(2, {6'h0, s});
    csr_write(3, {6'h0, d});
    csr_write(4, {16'h0, n});
  endtask

  initial begin
    logic [31:0] sum;
    int base_rd, base_wr, k;
    reset = 1'b1;
    slave_address = 3'd0; slave_writedata = 32'h0;
    slave_write = 1'b0; slave_read = 1'b0; slave_chipselect = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 ^ (i << 12) ^ i;
    mem[16] = 32'hFFFF_FFFF;
    mem[17] = 32'h0000_0002;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mread", master_read, 0);
    chk("reset_mwrite", master_write, 0);
    chk("reset_irq", irq, 0);
    chk("reset_rdata", slave_readdata, 0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) csr_read(a, 32'h0, $sformatf("reset_csr%0d", a));

    csr_write(7, 32'hDEAD_BEEF);
    csr_read(7, 32'hDEAD_BEEF, "scratch");
    csr_write(0, 32'h4);
    csr_read(0, 32'h4, "ctrl_irq_en");

    // Basic 4-word copy
    setup(26'h100, 26'h200, 16'd4);
    push_transfer(26'h100, 26'h200, 4);
    sum = mem[0] + mem[1] + mem[2] + mem[3];
`ifndef MOVER_CHECKSUM_EN
    sum = 32'h0;
`endif
    csr_write(0, 32'h5);
    wait_irq("basic_irq");
    csr_read(1, 32'h2, "basic_status");
    csr_read(5, 32'h4, "basic_count");
    csr_read(6, sum, "basic_checksum");
    csr_read(2, 32'h100, "basic_src_kept");
    csr_write(1, 32'h2);
    chk("irq_cleared", irq, 0);
    csr_read(1, 32'h0, "status_w1c");

    // Zero length
    csr_write(4, 32'h0);
    csr_write(0, 32'h5);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("len0_done_2cyc", irq, 1);
    csr_read(5, 32'h0, "len0_count");
    csr_write(1, 32'h2);

    // Address wrap at the top of the master space
    setup(26'h3FF_FFFC, 26'h3FF_FFF8, 16'd2);
    push_transfer(26'h3FF_FFFC, 26'h3FF_FFF8, 2);
    csr_write(0, 32'h5);
    wait_irq("wrap_irq");
    csr_read(5, 32'h2, "wrap_count");
    csr_write(1, 32'h2);

    // Waitrequest stalls, busy-time writes ignored, live COUNT
    wait_n = 3;
    setup(26'h120, 26'h300, 16'd3);
    push_transfer(26'h120, 26'h300, 3);
    base_rd = rd_accepts;
    base_wr = wr_accepts;
    csr_write(0, 32'h5);
    repeat (2) @(posedge clk);
    csr_read(1, 32'h1, "busy_status");
    csr_write(4, 32'h9);
    csr_write(2, 32'h999);
    csr_write(0, 32'h5);
    csr_read(4, 32'h3, "len_locked");
    csr_read(2, 32'h120, "src_locked");
    k = 0;
    while (wr_accepts < base_wr + 1 && k < 500) begin @(posedge clk); k++; end
    csr_read(5, 32'h1, "count_live");
    wait_irq("wait_irq");
    chk("wait_reads", rd_accepts - base_rd, 3);
    chk("wait_writes", wr_accepts - base_wr, 3);
    csr_read(5, 32'h3, "wait_count");
    csr_write(1, 32'h2);
    wait_n = 0;

    // Abort during RD_WAIT of the second word
    setup(26'h180, 26'h400, 16'd8);
    push_word(26'h180, 26'h400);
    push_read(26'h184);
    base_rd = rd_accepts;
    csr_write(0, 32'h5);
    k = 0;
    while (rd_accepts < base_rd + 2 && k < 500) begin @(posedge clk); k++; end
    csr_write(0, 32'h6);
    repeat (10) @(posedge clk);
    csr_read(1, 32'h4, "abort_status");
    csr_read(5, 32'h1, "abort_count");
    chk("abort_irq", irq, 0);
    chk("abort_wr_drained", exp_wr_q.size(), 0);
    csr_write(1, 32'h4);
    csr_read(1, 32'h0, "aborted_w1c");

    // Checksum wrap: 0xFFFFFFFF + 2
    setup(26'h040, 26'h500, 16'd2);
    push_transfer(26'h040, 26'h500, 2);
    csr_write(0, 32'h5);
    wait_irq("cks_irq");
`ifdef MOVER_CHECKSUM_EN
    csr_read(6, 32'h1, "checksum");
`else
    csr_read(6, 32'h0, "checksum");
`endif
    csr_write(1, 32'h2);

    // Start together with abort: nothing runs
    setup(26'h100, 26'h200, 16'd2);
    csr_write(0, 32'h7);
    repeat (10) @(posedge clk);
    csr_read(1, 32'h0, "start_abort_status");
    chk("start_abort_irq", irq, 0);

    // Reset while a write is held
    wait_n = 3;
    setup(26'h100, 26'h600, 16'd4);
    push_read(26'h100);
    csr_write(0, 32'h5);
    k = 0;
    while (!(master_write && master_waitrequest) && k < 500) begin @(negedge clk); k++; end
    chk("reset_found_wr", master_write, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mwrite", master_write, 0);
    chk("rst_maddr", master_address, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_n = 0;
    for (int a = 0; a < 8; a++) csr_read(a, 32'h0, $sformatf("rst_csr%0d", a));
    setup(26'h100, 26'h700, 16'd2);
    push_transfer(26'h100, 26'h700, 2);
    csr_write(0, 32'h5);
    wait_irq("post_rst_irq");
    csr_read(5, 32'h2, "post_rst_count");
    csr_read(1, 32'h2, "post_rst_status");

    repeat (4) @(posedge clk);
    chk("final_rd_q", exp_rd_q.size(), 0);
    chk("final_wr_q", exp_wr_q.size(), 0);
    chk("final_csr_q", exp_csr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
